// File: rtl/booth_mul32_seq.sv
// Sequential signed 32x32->64 radix-2 Booth multiplier for the ALU MUL path.
// Each iteration adds/subtracts M via a shared 32-bit CLA, then arithmetic-shifts.

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups; group carries chain through group generate/propagate
  always_comb begin
    c    = '0;
    gg   = '0;
    gp   = '0;
    c[0] = ci;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
  end

  assign sum = p ^ c[31:0];
  assign co  = c[32];
endmodule

module booth_mul32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        op_done,
  output logic [63:0] result
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] m_q, m_d;
  logic        [63:0] res_q, res_d;
  logic               prev_q, prev_d;
  logic        [4:0]  cnt_q, cnt_d;

  logic [31:0] add_b;
  logic        add_ci;
  logic [31:0] add_sum;
  logic        add_co;
  logic        sign_ext;

  // Booth recode of {result[0], prev}: 01 adds M, 10 adds ~M+1, else adds zero
  always_comb begin
    add_b  = '0;
    add_ci = 1'b0;
    case ({res_q[0], prev_q})
      2'b01:   add_b = m_q;
      2'b10: begin
        add_b  = ~m_q;
        add_ci = 1'b1;
      end
      default: add_b = '0;
    endcase
  end

  cla32 u_cla (
    .a   (res_q[63:32]),
    .b   (add_b),
    .ci  (add_ci),
    .sum (add_sum),
    .co  (add_co)
  );

  // Bit 32 of the sign-extended sum: equals sum[31] XOR signed overflow, so M = -2^31 works
  assign sign_ext = res_q[63] ^ add_b[31] ^ add_co;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    res_d   = res_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    if (op_clear) begin
      state_d = IDLE;
      res_d   = '0;
      prev_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_start) begin
            state_d = EXEC;
            m_d     = multiplicand;
            res_d   = {32'h0, multiplier};
            prev_d  = 1'b0;
            cnt_d   = '0;
          end
        end
        EXEC: begin
          res_d  = {sign_ext, add_sum, res_q[31:1]};
          prev_d = res_q[0];
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      res_q   <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      res_q   <= res_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == EXEC);
  assign op_done = (state_q == DONE);
  assign result  = res_q;
endmodule
